// File: rtl/ctrl_pkg.sv
// Shared types and default opcode constants for the multicycle controller.
// Optional performance counters in the top level are built only when CTRL_PERF_CNT_EN is defined.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_HALT  = 3'd4
    } op_class_t;

    localparam logic [3:0]  DEFAULT_STORE_OP = 4'b0100;
    localparam logic [3:0]  DEFAULT_LOAD_OP  = 4'b0101;
    localparam logic [3:0]  DEFAULT_HALT_OP  = 4'b1111;
    // Opcodes 1,2,3 and 8..13 are ALU class.
    localparam logic [15:0] DEFAULT_ALU_MASK = 16'h3F0E;

endpackage

// File: rtl/multicycle_controller_op_class_decode.sv
// Combinational opcode classifier. HALT is checked first so it wins over an
// overlapping ALU mask bit, then ALU, then load/store; anything else is a NOP.
module op_class_decode
    import ctrl_pkg::*;
#(
    parameter int                 OP_W     = 4,
    parameter logic [2**OP_W-1:0] ALU_MASK = DEFAULT_ALU_MASK,
    parameter logic [OP_W-1:0]    STORE_OP = DEFAULT_STORE_OP,
    parameter logic [OP_W-1:0]    LOAD_OP  = DEFAULT_LOAD_OP,
    parameter logic [OP_W-1:0]    HALT_OP  = DEFAULT_HALT_OP
) (
    input  logic [OP_W-1:0] op_code,
    output op_class_t       op_class
);

    always_comb begin
        op_class = CLS_NOP;
        if (op_code == HALT_OP) begin
            op_class = CLS_HALT;
        end else if (ALU_MASK[op_code]) begin
            op_class = CLS_ALU;
        end else if (op_code == STORE_OP) begin
            op_class = CLS_STORE;
        end else if (op_code == LOAD_OP) begin
            op_class = CLS_LOAD;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback with
// request/acknowledge handshakes. Define CTRL_PERF_CNT_EN to build the retired/stall counters.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int                 OP_W     = 4,
    parameter logic [2**OP_W-1:0] ALU_MASK = DEFAULT_ALU_MASK,
    parameter logic [OP_W-1:0]    STORE_OP = DEFAULT_STORE_OP,
    parameter logic [OP_W-1:0]    LOAD_OP  = DEFAULT_LOAD_OP,
    parameter logic [OP_W-1:0]    HALT_OP  = DEFAULT_HALT_OP,
    parameter int                 CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op_code,
    output logic             if_req,
    input  logic             if_ack,
    output logic             ir_load,
    output logic             alu_en,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             data_write_en,
    output logic             reg_write_en,
    output logic             mem_to_reg,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t          state_reg, state_next;
    logic [OP_W-1:0] op_reg;
    op_class_t       op_class;

    op_class_decode #(
        .OP_W     (OP_W),
        .ALU_MASK (ALU_MASK),
        .STORE_OP (STORE_OP),
        .LOAD_OP  (LOAD_OP),
        .HALT_OP  (HALT_OP)
    ) u_decode (
        .op_code  (op_reg),
        .op_class (op_class)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FETCH && if_ack) begin
                op_reg <= op_code;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        if_req        = 1'b0;
        ir_load       = 1'b0;
        alu_en        = 1'b0;
        dmem_req      = 1'b0;
        data_write_en = 1'b0;
        reg_write_en  = 1'b0;
        mem_to_reg    = 1'b0;
        pc_en         = 1'b0;
        halted        = 1'b0;
        case (state_reg)
            FETCH: begin
                if_req = 1'b1;
                if (if_ack) begin
                    ir_load    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (op_class)
                    CLS_HALT:                     state_next = HALTED;
                    CLS_ALU, CLS_LOAD, CLS_STORE: state_next = EXEC;
                    default: begin
                        pc_en      = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            EXEC: begin
                alu_en     = 1'b1;
                state_next = (op_class == CLS_ALU) ? WB : MEM;
            end
            MEM: begin
                dmem_req      = 1'b1;
                data_write_en = (op_class == CLS_STORE);
                if (dmem_ack) begin
                    if (op_class == CLS_STORE) begin
                        pc_en      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                reg_write_en = 1'b1;
                pc_en        = 1'b1;
                mem_to_reg   = (op_class == CLS_LOAD);
                state_next   = FETCH;
            end
            HALTED: halted = 1'b1;
            default: state_next = FETCH;
        endcase
        // Reset must silence everything immediately, including the FETCH request.
        if (rst) begin
            state_next    = FETCH;
            if_req        = 1'b0;
            ir_load       = 1'b0;
            alu_en        = 1'b0;
            dmem_req      = 1'b0;
            data_write_en = 1'b0;
            reg_write_en  = 1'b0;
            mem_to_reg    = 1'b0;
            pc_en         = 1'b0;
            halted        = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_reg, stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_reg <= '0;
            stall_reg   <= '0;
        end else begin
            if (pc_en) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
            if ((if_req & ~if_ack) | (dmem_req & ~dmem_ack)) begin
                stall_reg <= stall_reg + CNT_W'(1);
            end
        end
    end

    assign retired_cnt = retired_reg;
    assign stall_cnt   = stall_reg;
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// output trace from the phase rules, then driven and compared cycle by cycle.
module tb_multicycle_controller;

    localparam logic [8:0] O_IFREQ  = 9'b1_0000_0000;
    localparam logic [8:0] O_IRLOAD = 9'b0_1000_0000;
    localparam logic [8:0] O_ALU    = 9'b0_0100_0000;
    localparam logic [8:0] O_DMEM   = 9'b0_0010_0000;
    localparam logic [8:0] O_DWE    = 9'b0_0001_0000;
    localparam logic [8:0] O_RWE    = 9'b0_0000_1000;
    localparam logic [8:0] O_M2R    = 9'b0_0000_0100;
    localparam logic [8:0] O_PC     = 9'b0_0000_0010;
    localparam logic [8:0] O_HALT   = 9'b0_0000_0001;

    typedef struct packed {
        logic [4:0] op;
        logic       ia;
        logic       da;
        logic [8:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  op_code = '0;
    logic        if_ack = 1'b0, dmem_ack = 1'b0;
    logic        if_req, ir_load, alu_en, dmem_req, data_write_en;
    logic        reg_write_en, mem_to_reg, pc_en, halted;
    logic [31:0] retired_cnt, stall_cnt;

    logic [4:0]  op_code5 = '0;
    logic        if_ack5 = 1'b0, dmem_ack5 = 1'b0;
    logic        if_req5, ir_load5, alu_en5, dmem_req5, data_write_en5;
    logic        reg_write_en5, mem_to_reg5, pc_en5, halted5;
    logic [31:0] retired_cnt5, stall_cnt5;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op_code(op_code),
        .if_req(if_req), .if_ack(if_ack), .ir_load(ir_load), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .data_write_en(data_write_en),
        .reg_write_en(reg_write_en), .mem_to_reg(mem_to_reg), .pc_en(pc_en),
        .halted(halted), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    multicycle_controller #(
        .OP_W(5), .ALU_MASK(32'h0010_3F0E), .STORE_OP(5'd4),
        .LOAD_OP(5'd5), .HALT_OP(5'd31)
    ) dut5 (
        .clk(clk), .rst(rst), .op_code(op_code5),
        .if_req(if_req5), .if_ack(if_ack5), .ir_load(ir_load5), .alu_en(alu_en5),
        .dmem_req(dmem_req5), .dmem_ack(dmem_ack5), .data_write_en(data_write_en5),
        .reg_write_en(reg_write_en5), .mem_to_reg(mem_to_reg5), .pc_en(pc_en5),
        .halted(halted5), .retired_cnt(retired_cnt5), .stall_cnt(stall_cnt5)
    );

    wire [8:0] outv  = {if_req, ir_load, alu_en, dmem_req, data_write_en,
                        reg_write_en, mem_to_reg, pc_en, halted};
    wire [8:0] outv5 = {if_req5, ir_load5, alu_en5, dmem_req5, data_write_en5,
                        reg_write_en5, mem_to_reg5, pc_en5, halted5};

    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    bit   use5 = 1'b0;
    int   ret_m = 0;
    int   stall_m = 0;
    cyc_t plan[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef CTRL_PERF_CNT_EN
        return 32'(v);
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] rop();
        return 5'($urandom_range(0, use5 ? 31 : 15));
    endfunction

    function automatic cyc_t mk(input logic [4:0] op, input logic ia, input logic da, input logic [8:0] e);
        cyc_t c;
        c.op = op; c.ia = ia; c.da = da; c.exp = e;
        return c;
    endfunction

    // 0 nop, 1 alu, 2 load, 3 store, 4 halt, in the classification priority order.
    function automatic int classify(input int op);
        logic [31:0] mask;
        int halt_op;
        mask    = use5 ? 32'h0010_3F0E : 32'h0000_3F0E;
        halt_op = use5 ? 31 : 15;
        if (op == halt_op) return 4;
        if (mask[op]) return 1;
        if (op == 4) return 3;
        if (op == 5) return 2;
        return 0;
    endfunction

    task automatic build(input int op, input int fw, input int mw);
        int cls;
        cls = classify(op);
        plan.delete();
        repeat (fw) plan.push_back(mk(rop(), 1'b0, rb(), O_IFREQ));
        plan.push_back(mk(5'(op), 1'b1, rb(), O_IFREQ | O_IRLOAD));
        plan.push_back(mk(rop(), rb(), rb(), (cls == 0) ? O_PC : 9'd0));
        if (cls >= 1 && cls <= 3) plan.push_back(mk(rop(), rb(), rb(), O_ALU));
        if (cls == 2 || cls == 3) begin
            repeat (mw) plan.push_back(mk(rop(), rb(), 1'b0, O_DMEM | ((cls == 3) ? O_DWE : 9'd0)));
            plan.push_back(mk(rop(), rb(), 1'b1, O_DMEM | ((cls == 3) ? (O_DWE | O_PC) : 9'd0)));
        end
        if (cls == 1 || cls == 2)
            plan.push_back(mk(rop(), rb(), rb(), O_RWE | O_PC | ((cls == 2) ? O_M2R : 9'd0)));
    endtask

    // Starts #1 after a rising edge; returns #1 after the next one.
    task automatic step(input cyc_t c);
        if (use5) begin
            op_code5 = c.op; if_ack5 = c.ia; dmem_ack5 = c.da;
            if_ack = 1'b0; dmem_ack = 1'b0;
        end else begin
            op_code = c.op[3:0]; if_ack = c.ia; dmem_ack = c.da;
            if_ack5 = 1'b0; dmem_ack5 = 1'b0;
        end
        @(negedge clk);
        check("outputs", {23'd0, use5 ? outv5 : outv}, {23'd0, c.exp});
        if (((c.exp & O_IFREQ) != 0 && !c.ia) || ((c.exp & O_DMEM) != 0 && !c.da)) stall_m++;
        if ((c.exp & O_PC) != 0) ret_m++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts();
        check("retired_cnt", use5 ? retired_cnt5 : retired_cnt, exp_cnt(ret_m));
        check("stall_cnt", use5 ? stall_cnt5 : stall_cnt, exp_cnt(stall_m));
    endtask

    task automatic run_instr(input int op, input int fw, input int mw);
        build(op, fw, mw);
        foreach (plan[i]) step(plan[i]);
        check_cnts();
        $display("instr dut%0s op=%0d class=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d",
                 use5 ? "5" : "4", op, classify(op), fw, mw, plan.size());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs", {23'd0, use5 ? outv5 : outv}, 32'd0);
        ret_m = 0; stall_m = 0;
        check_cnts();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_outputs_por", {14'd0, outv, outv5}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_held_outputs", {23'd0, outv}, 32'd0);
        check_cnts();
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(8, 0, 0);
        run_instr(4, 0, 3);
        run_instr(5, 0, 0);
        run_instr(6, 0, 0);
        for (int i = 0; i < 40; i++)
            run_instr($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3));

        // Store abandoned mid-MEM by an asynchronous reset.
        build(4, 0, 5);
        for (int i = 0; i < 5; i++) step(plan[i]);
        dmem_ack = 1'b0;
        do_reset();
        run_instr(6, 0, 0);
        $display("instr dut4 store aborted by reset in MEM");

        run_instr(15, 0, 0);
        for (int i = 0; i < 20; i++) step(mk(rop(), rb(), rb(), O_HALT));
        check_cnts();
        $display("instr dut4 halt held for 20 cycles");
        do_reset();
        run_instr(1, 1, 0);

        use5 = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) run_instr(20, (i < 5) ? 0 : $urandom_range(0, 2), 0);
        check("retired_after_10_alu", retired_cnt5, exp_cnt(10));
        run_instr(5, 1, 2);
        run_instr(31, 0, 0);
        step(mk(rop(), rb(), rb(), O_HALT));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
